// File: rtl/mem_io_bridge_pkg.sv
// rtl/mem_io_bridge_pkg.sv - shared FSM state type and I/O window constants
// Purpose: types and constants used by mem_io_bridge.
// Ports: none (package).
package mem_io_pkg;

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  localparam int OFS_SW   = 0;  // synchronised switch register, read-only
  localparam int OFS_OUT0 = 1;  // first output register
  localparam int IO_WIN   = 8;  // words in the decoded I/O window

endpackage

// File: rtl/mem_io_bridge_if.sv
// rtl/mem_io_bridge_if.sv - CPU-side request/ready memory interface
// Purpose: groups the CPU memory handshake so it travels as one port.
// Ports: Req/Wr/A/BE/Wr_Data from master, Rd_Data/Ready from slave.
interface mem_io_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic                  Req;
  logic                  Wr;
  logic [ADDR_W-1:0]     A;
  logic [DATA_W/8-1:0]   BE;
  logic [DATA_W-1:0]     Wr_Data;
  logic [DATA_W-1:0]     Rd_Data;
  logic                  Ready;

  modport master (output Req, Wr, A, BE, Wr_Data, input Rd_Data, Ready);
  modport slave  (input Req, Wr, A, BE, Wr_Data, output Rd_Data, Ready);
endinterface

// File: rtl/mem_io_bridge_sync2.sv
// rtl/mem_io_bridge_sync2.sv - parametrised-width two-flop synchroniser
// Purpose: brings asynchronous board inputs into the Clk domain.
// Ports: Clk, Reset (sync, active-high), d (async in), q (synchronised out).
module sync2 #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - CPU to SRAM / memory-mapped I/O bridge
// Purpose: decodes an 8-word I/O window (switches + output registers) at
//   IO_BASE on A[15:0]; all other accesses go to external SRAM with
//   MEM_WAIT extra wait cycles.
// Ports: Clk, Reset (sync, active-high); cpu (request/ready slave);
//   Switches (async in); Out_Regs (N_OUT packed words); Mem_A, Mem_CE_n,
//   Mem_OE_n, Mem_WE_n, Mem_BE_n (SRAM strobes, active-low); Data_Mem (inout).
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 20,
  parameter int          N_OUT    = 1,
  parameter int          MEM_WAIT = 1,
  parameter logic [15:0] IO_BASE  = 16'hFFF8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  mem_io_bridge_if.slave          cpu,
  input  logic [DATA_W-1:0]       Switches,
  output logic [N_OUT*DATA_W-1:0] Out_Regs,
  output logic [ADDR_W-1:0]       Mem_A,
  output logic                    Mem_CE_n,
  output logic                    Mem_OE_n,
  output logic                    Mem_WE_n,
  output logic [DATA_W/8-1:0]     Mem_BE_n,
  inout  wire  [DATA_W-1:0]       Data_Mem
);
  localparam int NB = DATA_W / 8;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rd_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   out_q [N_OUT];
  logic [DATA_W-1:0]   sw;
  logic [15:0]         io_off;
  logic                io_hit;
  logic                accept;
  logic [DATA_W-1:0]   io_rd;
  logic                drive;

  sync2 #(.W(DATA_W)) u_sw_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Switches),
    .q     (sw)
  );

  // Decode is done on the live request; the window wraps only within A[15:0].
  assign accept = (state == IDLE) && cpu.Req;
  assign io_off = cpu.A[15:0] - IO_BASE;
  assign io_hit = io_off < 16'(IO_WIN);

  // Unmapped offsets inside the window fall through to zero.
  always_comb begin
    io_rd = '0;
    if (io_off == 16'(OFS_SW)) io_rd = sw;
    for (int k = 0; k < N_OUT; k++)
      if (io_off == 16'(OFS_OUT0 + k)) io_rd = out_q[k];
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu.Req) state_next = io_hit ? DONE : MEM;
      MEM:     if (cnt_q == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Mem_CE_n = 1'b1;
    Mem_OE_n = 1'b1;
    Mem_WE_n = 1'b1;
    Mem_BE_n = '1;
    drive    = 1'b0;
    if (state == MEM) begin
      Mem_CE_n = 1'b0;
      Mem_BE_n = ~be_q;
      Mem_OE_n = wr_q;
      Mem_WE_n = ~wr_q;
      drive    = wr_q;
    end
  end

  // I/O results are known at accept, so rd_q is loaded on the edge entering
  // DONE for both paths; SRAM reads sample the bus on the MEM exit edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
      rd_q    <= '0;
    end else if (accept) begin
      addr_q  <= cpu.A;
      wr_q    <= cpu.Wr;
      be_q    <= cpu.BE;
      wdata_q <= cpu.Wr_Data;
      cnt_q   <= 4'(MEM_WAIT);
      if (io_hit) rd_q <= cpu.Wr ? '0 : io_rd;
    end else if (state == MEM) begin
      if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      else               rd_q  <= wr_q ? '0 : Data_Mem;
    end
  end

  // Output registers commit on the accept edge, which is the edge into DONE.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < N_OUT; k++) begin
      if (Reset) begin
        out_q[k] <= '0;
      end else if (accept && io_hit && cpu.Wr && io_off == 16'(OFS_OUT0 + k)) begin
        for (int b = 0; b < NB; b++)
          if (cpu.BE[b]) out_q[k][b*8 +: 8] <= cpu.Wr_Data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    Out_Regs = '0;
    for (int k = 0; k < N_OUT; k++) Out_Regs[k*DATA_W +: DATA_W] = out_q[k];
  end

  assign Mem_A       = addr_q;
  assign Data_Mem    = drive ? wdata_q : 'z;
  assign cpu.Ready   = (state == DONE);
  assign cpu.Rd_Data = rd_q;
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - self-checking bench for mem_io_bridge
module tb_mem_io_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int low2 = 0;

  logic        req = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [19:0] a = '0;
  logic [1:0]  be = '0;
  logic [15:0] wd = '0;
  logic [15:0] switches = '0;
  logic [15:0] exp_q[$];

  // sel = 0 targets dut0 (MEM_WAIT = 0), sel = 1 targets dut2 (MEM_WAIT = 2)
  mem_io_bridge_if #(.DATA_W(16), .ADDR_W(20)) bus0 ();
  mem_io_bridge_if #(.DATA_W(16), .ADDR_W(20)) bus2 ();

  assign bus0.Req = req & ~sel;
  assign bus0.Wr = wr;
  assign bus0.A = a;
  assign bus0.BE = be;
  assign bus0.Wr_Data = wd;
  assign bus2.Req = req & sel;
  assign bus2.Wr = wr;
  assign bus2.A = a;
  assign bus2.BE = be;
  assign bus2.Wr_Data = wd;

  logic [15:0] out0, out2;
  logic [19:0] mem_a0, mem_a2;
  logic        ce_n0, oe_n0, we_n0, ce_n2, oe_n2, we_n2;
  logic [1:0]  be_n0, be_n2;
  tri1  [15:0] dm0;
  tri1  [15:0] dm2;

  // SRAM model for dut0: drives read data only while output-enabled.
  assign dm0 = (!ce_n0 && !oe_n0) ? 16'h5A5A : 16'hzzzz;

  mem_io_bridge #(.DATA_W(16), .ADDR_W(20), .N_OUT(1), .MEM_WAIT(0), .IO_BASE(16'hFFF8)) dut0 (
    .Clk(clk), .Reset(reset), .cpu(bus0), .Switches(switches), .Out_Regs(out0),
    .Mem_A(mem_a0), .Mem_CE_n(ce_n0), .Mem_OE_n(oe_n0), .Mem_WE_n(we_n0),
    .Mem_BE_n(be_n0), .Data_Mem(dm0)
  );

  mem_io_bridge #(.DATA_W(16), .ADDR_W(20), .N_OUT(1), .MEM_WAIT(2), .IO_BASE(16'hFFF8)) dut2 (
    .Clk(clk), .Reset(reset), .cpu(bus2), .Switches(switches), .Out_Regs(out2),
    .Mem_A(mem_a2), .Mem_CE_n(ce_n2), .Mem_OE_n(oe_n2), .Mem_WE_n(we_n2),
    .Mem_BE_n(be_n2), .Data_Mem(dm2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // dut2 only ever performs SRAM writes of 16'h1234 to 20'h00123.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!ce_n2) begin
        low2++;
        check("mem2_we", 32'(we_n2), 0);
        check("mem2_oe", 32'(oe_n2), 1);
        check("mem2_a", 32'(mem_a2), 32'h00123);
        check("mem2_be", 32'(be_n2), 0);
        check("mem2_data", 32'(dm2), 32'h1234);
      end else begin
        check("mem2_idle_strb", 32'({oe_n2, we_n2, be_n2}), 32'hF);
        check("mem2_idle_bus", 32'(dm2), 32'hFFFF);
      end
    end
  end

  // dut0 only ever performs SRAM reads from 20'h00456.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!ce_n0) begin
        check("mem0_oe", 32'(oe_n0), 0);
        check("mem0_we", 32'(we_n0), 1);
        check("mem0_a", 32'(mem_a0), 32'h00456);
        check("mem0_data", 32'(dm0), 32'h5A5A);
      end else begin
        check("mem0_idle_strb", 32'({oe_n0, we_n0, be_n0}), 32'hF);
        check("mem0_idle_bus", 32'(dm0), 32'hFFFF);
      end
    end
  end

  task automatic access(input logic s, input logic w, input logic [19:0] addr,
                        input logic [1:0] b, input logic [15:0] d,
                        input logic [15:0] exp_rd, input int exp_lat, input string tag);
    int n;
    logic [15:0] e;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    sel = s; req = 1'b1; wr = w; a = addr; be = b; wd = d;
    @(posedge clk);
    #1 req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s ? bus2.Ready : bus0.Ready) && n < 20);
    check({tag, "_ready"}, 32'(s ? bus2.Ready : bus0.Ready), 1);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    e = exp_q.pop_front();
    check({tag, "_rd"}, 32'(s ? bus2.Rd_Data : bus0.Rd_Data), 32'(e));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(s ? bus2.Ready : bus0.Ready), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_ready2", 32'(bus2.Ready), 0);
      check("rst_ready0", 32'(bus0.Ready), 0);
      check("rst_out2", 32'(out2), 0);
      check("rst_out0", 32'(out0), 0);
      check("rst_rd2", 32'(bus2.Rd_Data), 0);
    end

    access(1'b1, 1'b1, 20'h0FFF9, 2'b01, 16'hABCD, 16'h0000, 1, "ow1");
    check("out_lo", 32'(out2), 32'h00CD);
    access(1'b1, 1'b1, 20'h0FFF9, 2'b11, 16'h1234, 16'h0000, 1, "ow2");
    check("out_full", 32'(out2), 32'h1234);
    access(1'b1, 1'b1, 20'hAFFF9, 2'b10, 16'h5600, 16'h0000, 1, "ow3");
    check("out_hi", 32'(out2), 32'h5634);

    @(negedge clk);
    switches = 16'hBEEF;
    repeat (2) @(negedge clk);
    access(1'b1, 1'b0, 20'h0FFF8, 2'b11, 16'h0000, 16'hBEEF, 1, "sw_rd");
    access(1'b1, 1'b0, 20'h0FFF9, 2'b00, 16'h0000, 16'h5634, 1, "out_rd");
    access(1'b1, 1'b0, 20'h0FFFE, 2'b11, 16'h0000, 16'h0000, 1, "unmapped");
    access(1'b1, 1'b1, 20'h0FFF8, 2'b11, 16'h0000, 16'h0000, 1, "sw_wr");
    access(1'b1, 1'b0, 20'h0FFF8, 2'b11, 16'h0000, 16'hBEEF, 1, "sw_rd2");
    check("out_kept", 32'(out2), 32'h5634);

    low2 = 0;
    access(1'b1, 1'b1, 20'h00123, 2'b11, 16'h1234, 16'h0000, 4, "sram_wr");
    check("sram_wr_cycles", 32'(low2), 3);
    access(1'b0, 1'b0, 20'h00456, 2'b11, 16'h0000, 16'h5A5A, 2, "sram_rd");

    // Abort an SRAM write with reset during its second MEM cycle.
    @(negedge clk);
    sel = 1'b1; req = 1'b1; wr = 1'b1; a = 20'h00123; be = 2'b11; wd = 16'h1234;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("abort_mem1", 32'(ce_n2), 0);
    @(negedge clk);
    check("abort_mem2", 32'(ce_n2), 0);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_ready", 32'(bus2.Ready), 0);
      check("abort_ce", 32'(ce_n2), 1);
    end
    check("abort_out", 32'(out2), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    access(1'b1, 1'b0, 20'h0FFF8, 2'b11, 16'h0000, 16'hBEEF, 1, "post_rst");
    access(1'b1, 1'b1, 20'h0FFF9, 2'b11, 16'h7777, 16'h0000, 1, "post_wr");
    check("post_out", 32'(out2), 32'h7777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
